regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file with a per-register busy scoreboard, successor to the single-write, two-read integer register file of the Strontium core. It sits between decode/issue (read ports, busy claims) and writeback (write ports). It supports dual-issue and multi-cycle units. Register 0 is hardwired to zero. Reads are combinational. Writes and scoreboard updates commit on the rising clock edge.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 2, write ports (1..2)

Ports (port p occupies slice [p*W +: W] of its flat bus):
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- we  in  NUM_WR  write enable per write port
- waddr  in  NUM_WR*ADDR_W  write addresses
- wdata  in  NUM_WR*DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  read addresses
- rdata  out  NUM_RD*DATA_W  read data, combinational
- rbusy  out  NUM_RD  busy bit of the register addressed by each read port
- claim  in  1  mark the register at claim_addr as awaiting a result
- claim_addr  in  ADDR_W  register being claimed
- busy  out  DEPTH  registered scoreboard vector; bit 0 is always 0

## Operation
- Reset: while reset=1 at a rising edge, all registers become 0 and busy becomes all-zero. Reset has priority over every write and claim in that cycle.
- Write: when we[p]=1 and waddr[p]!=0, register waddr[p] takes wdata[p] at the edge. A write to address 0 is discarded.
- Write collision: if both ports write the same address in one cycle, port 1 (the higher index) wins.
- Read: rdata[q] is the array value at raddr[q]. raddr=0 always returns 0.
- Scoreboard set: claim=1 with claim_addr!=0 sets busy[claim_addr] at the edge. A claim of address 0 is ignored.
- Scoreboard clear: an accepted write (we=1, addr!=0) clears busy[waddr] at the edge.
- Simultaneous claim and write to the same address: the claim wins and busy stays 1, because a new producer supersedes the retiring one. The write data is still stored.
- rbusy[q] = busy[raddr[q]], with forwarding as defined under Configuration.

## Timing
- Read path is combinational from raddr to rdata and rbusy, with zero latency.
- Write-to-read latency is 1 cycle without bypass and 0 cycles with bypass.
- A claim becomes visible on busy and rbusy in the cycle after the claim edge.
- Reset applies at the first rising edge with reset=1; outputs read 0 from the following cycle.
- No handshakes. Every input is sampled every cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose raddr matches an active same-cycle write (we=1, addr!=0) returns that wdata. Port 1 has priority if both ports match.
  - rbusy for that read is 0 unless claim targets the same address in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - Reads return the pre-edge array contents.
  - rbusy reflects the registered busy bit only.

## Structure
- Package regfile_pkg holds:
  - default DATA_W, ADDR_W, NUM_RD, NUM_WR
  - localparam ZERO_REG = 0
  - a function that slices one port field out of a flat bus
- One sub-module is natural: regfile_scoreboard. It owns the busy vector and the set/clear/priority rules, and also serves the FP register file.
- Target size is 150–300 lines in total.

## Test plan
- Reset: write 0xDEADBEEF to r5, then hold reset=1 for 1 cycle → r5 reads 0 and busy=0.
- r0 immunity: write r0=0x1234 via both ports → raddr=0 returns 0. Claim r0 → busy[0] stays 0.
- Collision: port0 writes r7=0xAAAA0000 and port1 writes r7=0x5555FFFF in the same cycle → r7=0x5555FFFF.
- Bypass: write r3=0xCAFEF00D while raddr=3 in the same cycle.
  - With REGFILE_BYPASS_EN: rdata=0xCAFEF00D in that cycle.
  - Without it: rdata=the old value, then 0xCAFEF00D on the next cycle.
- Scoreboard: claim r9 → busy[9]=1 next cycle. Write r9=0x42 → busy[9]=0 and r9=0x42.
- Claim/write race: r9 is busy; claim r9 and write r9=0x77 in the same cycle → r9=0x77 and busy[9] remains 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

  localparam int ZERO_REG = 0;

  // Widest flat bus and widest single field the slicing helper handles.
  localparam int MAX_BUS_W   = 1024;
  localparam int MAX_FIELD_W = 64;

  // Extract field p of width w from a flat bus whose port p sits at [p*w +: w].
  function automatic logic [MAX_FIELD_W-1:0] port_field(input logic [MAX_BUS_W-1:0] bus,
                                                        input int p,
                                                        input int w);
    logic [MAX_BUS_W-1:0]   sh;
    logic [MAX_FIELD_W-1:0] field;
    sh = bus >> (p * w);
    for (int i = 0; i < MAX_FIELD_W; i++) begin
      field[i] = (i < w) ? sh[i] : 1'b0;
    end
    return field;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: claims set, accepted writes clear, claim beats clear.
// Shared between the integer and FP register files.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_WR = DEF_NUM_WR,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic                     claim,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [DEPTH-1:0]         busy
);

  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W-1:0] wa [NUM_WR];

  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NUM_WR; p++) begin
      wa[p] = ADDR_W'(port_field(MAX_BUS_W'(waddr), p, ADDR_W));
      if (we[p] && (wa[p] != ADDR_W'(ZERO_REG))) begin
        busy_nxt[wa[p]] = 1'b0;
      end
    end
    // A new producer supersedes the one retiring in the same cycle.
    if (claim && (claim_addr != ADDR_W'(ZERO_REG))) begin
      busy_nxt[claim_addr] = 1'b1;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file (r0 hardwired to zero) with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     claim,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [DEPTH-1:0]         busy
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0] wr_act;
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [DATA_W-1:0] rval [NUM_RD];
  logic [NUM_RD-1:0] rbsy;

  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      wa[p]     = ADDR_W'(port_field(MAX_BUS_W'(waddr), p, ADDR_W));
      wd[p]     = DATA_W'(port_field(MAX_BUS_W'(wdata), p, DATA_W));
      wr_act[p] = we[p] && (wa[p] != ADDR_W'(ZERO_REG));
    end
  end

  // Ports are applied in index order so the higher port wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_act[p]) begin
          regs[wa[p]] <= wd[p];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int q = 0; q < NUM_RD; q++) begin
      ra[q]   = ADDR_W'(port_field(MAX_BUS_W'(raddr), q, ADDR_W));
      rval[q] = (ra[q] == ADDR_W'(ZERO_REG)) ? '0 : regs[ra[q]];
      rbsy[q] = busy[ra[q]];
`ifdef REGFILE_BYPASS_EN
      // A forwarded result is no longer pending unless re-claimed this cycle.
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_act[p] && (wa[p] == ra[q])) begin
          rval[q] = wd[p];
          rbsy[q] = claim && (claim_addr == ra[q]);
        end
      end
`endif
      rdata[q*DATA_W +: DATA_W] = rval[q];
      rbusy[q]                  = rbsy[q];
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR),
    .DEPTH  (DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .waddr      (waddr),
    .claim      (claim),
    .claim_addr (claim_addr),
    .busy       (busy)
  );

endmodule
